ram_partition_decode_ctrl: RTL



---
 rtl/ram_partition_decode_ctrl_pkg.sv | 27 ++
 rtl/ram_partition_decode_ctrl_onehot_decoder.sv | 27 ++
 rtl/ram_partition_decode_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_partition_decode_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_partition_decode_ctrl_pkg
//   Shared types and helpers for the partitioned-RAM decode controller.
//   - pgState_e : power-gating sequencer states.
//   - partOf()  : partition number of a binary RAM index. The partition is
//                 taken from the top partsLog bits of the index.
// ---------------------------------------------------------------------------
package ram_partition_decode_ctrl_pkg;

    typedef enum logic [1:0] {
        PG_ACTIVE     = 2'd0,
        PG_DRAIN      = 2'd1,
        PG_SETTLE     = 2'd2,
        PG_WAIT_READY = 2'd3
    } pgState_e;

    // Partition = index[indexWidth-1 -: partsLog], written as a shift so the
    // widths can stay generic.
    function automatic int unsigned partOf(
        input int unsigned index,
        input int unsigned indexWidth,
        input int unsigned partsLog
    );
        return index >> (indexWidth - partsLog);
    endfunction

endpackage

// File: rtl/ram_partition_decode_ctrl_onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
//   Combinational binary-to-one-hot word-line decoder with enable.
//   Ports:
//     index    [INDEX]  binary entry index
//     en       1        drive the word line; all-zero output when low
//     wordLine [DEPTH]  one-hot word line (1 << index)
// ---------------------------------------------------------------------------
module onehot_decoder #(
    parameter int INDEX = 6,
    parameter int DEPTH = 64
) (
    input  logic [INDEX-1:0] index,
    input  logic             en,
    output logic [DEPTH-1:0] wordLine
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        wordLine = '0;
        if (en) begin
            wordLine[index] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_partition_decode_ctrl.sv
// ---------------------------------------------------------------------------
// ram_partition_decode_ctrl
//   Front end of the partitioned no-decode RAM. Turns binary read/write
//   indices into registered one-hot word lines plus the per-read-port
//   partition select for the RAM output mux, and sequences partition power
//   gating (drain, gate/ungate, settle, wait for RAM ready). Accesses aimed
//   at a gated partition are dropped and flagged.
//
//   Ports:
//     clk                 clock, rising edge
//     reset               synchronous, active-low
//     rdIndex_i/rdEn_i    read indices and valids
//     wrIndex_i/wrEn_i    write indices and valids
//     partEnReq_i         requested enabled-partition mask
//     reconfigReq_i       one-cycle request to apply partEnReq_i
//     ramReady_i          RAM ready after (un)gating
//     addr_o              one-hot read word lines (registered)
//     rdDataPartition_o   registered partition select per read port
//     addrWr_o            one-hot write word lines (registered)
//     wrEn_o              qualified write enables (registered)
//     partitionGated_o    1 = partition gated
//     stall_o             accesses not accepted this cycle
//     accessFault_o       an access hit a gated partition (registered)
//     reconfigDone_o      one-cycle pulse at end of a reconfiguration
// ---------------------------------------------------------------------------
module ram_partition_decode_ctrl
    import ram_partition_decode_ctrl_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int INDEX         = 6,
    parameter int NUM_RD_PORTS  = 4,
    parameter int NUM_WR_PORTS  = 2,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]            rdIndex_i,
    input  logic [NUM_RD_PORTS-1:0]                       rdEn_i,
    input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]            wrIndex_i,
    input  logic [NUM_WR_PORTS-1:0]                       wrEn_i,
    input  logic [NUM_PARTS-1:0]                          partEnReq_i,
    input  logic                                          reconfigReq_i,
    input  logic                                          ramReady_i,
    output logic [NUM_RD_PORTS-1:0][DEPTH-1:0]            addr_o,
    output logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0]    rdDataPartition_o,
    output logic [NUM_WR_PORTS-1:0][DEPTH-1:0]            addrWr_o,
    output logic [NUM_WR_PORTS-1:0]                       wrEn_o,
    output logic [NUM_PARTS-1:0]                          partitionGated_o,
    output logic                                          stall_o,
    output logic                                          accessFault_o,
    output logic                                          reconfigDone_o
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    pgState_e             state, stateNext;
    logic [CNT_W-1:0]     settleCnt, settleCntNext;
    logic [NUM_PARTS-1:0] targetMask, targetMaskNext;
    logic [NUM_PARTS-1:0] gatedNext;
    logic [NUM_PARTS-1:0] reqMask;
    logic                 donePending, donePendingNext;
    logic                 doneNext;
    logic                 stall;

    // Stall is a pure decode of the state register, so it is stable for the
    // whole cycle and the upstream stage can use it combinationally.
    assign stall   = (state != PG_ACTIVE);
    assign stall_o = stall;

    // Partition 0 can never be gated.
    assign reqMask = partEnReq_i | NUM_PARTS'(1);

    // ---------------------------------------------------------------- decode
    logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0] rdPart;
    logic [NUM_RD_PORTS-1:0]                    rdAccept, rdFault;
    logic [NUM_RD_PORTS-1:0][DEPTH-1:0]         rdLine;

    logic [NUM_WR_PORTS-1:0][NUM_PARTS_LOG-1:0] wrPart;
    logic [NUM_WR_PORTS-1:0]                    wrAccept, wrFault;
    logic [NUM_WR_PORTS-1:0][DEPTH-1:0]         wrLine;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gRd
        assign rdPart[p]   = NUM_PARTS_LOG'(partOf(32'(rdIndex_i[p]), INDEX, NUM_PARTS_LOG));
        assign rdAccept[p] = rdEn_i[p] & ~stall & ~partitionGated_o[rdPart[p]];
        // Enables seen while stalled are dropped silently, never faulted.
        assign rdFault[p]  = rdEn_i[p] & ~stall &  partitionGated_o[rdPart[p]];

        onehot_decoder #(
            .INDEX (INDEX),
            .DEPTH (DEPTH)
        ) uRdDec (
            .index    (rdIndex_i[p]),
            .en       (rdAccept[p]),
            .wordLine (rdLine[p])
        );
    end

    for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : gWr
        assign wrPart[p]   = NUM_PARTS_LOG'(partOf(32'(wrIndex_i[p]), INDEX, NUM_PARTS_LOG));
        assign wrAccept[p] = wrEn_i[p] & ~stall & ~partitionGated_o[wrPart[p]];
        assign wrFault[p]  = wrEn_i[p] & ~stall &  partitionGated_o[wrPart[p]];

        onehot_decoder #(
            .INDEX (INDEX),
            .DEPTH (DEPTH)
        ) uWrDec (
            .index    (wrIndex_i[p]),
            .en       (wrAccept[p]),
            .wordLine (wrLine[p])
        );
    end

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_o            <= '0;
            rdDataPartition_o <= '0;
            addrWr_o          <= '0;
            wrEn_o            <= '0;
            accessFault_o     <= 1'b0;
        end else begin
            addr_o            <= rdLine;
            // Select follows the index even for blocked reads so the output
            // mux never sees a stale select.
            rdDataPartition_o <= rdPart;
            addrWr_o          <= wrLine;
            wrEn_o            <= wrAccept;
            accessFault_o     <= |{rdFault, wrFault};
        end
    end

    // ------------------------------------------------------- gating sequencer
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= PG_WAIT_READY;
            settleCnt        <= '0;
            targetMask       <= '1;
            partitionGated_o <= '0;
            donePending      <= 1'b0;
            reconfigDone_o   <= 1'b0;
        end else begin
            state            <= stateNext;
            settleCnt        <= settleCntNext;
            targetMask       <= targetMaskNext;
            partitionGated_o <= gatedNext;
            donePending      <= donePendingNext;
            reconfigDone_o   <= doneNext;
        end
    end

    always_comb begin
        stateNext       = state;
        settleCntNext   = settleCnt;
        targetMaskNext  = targetMask;
        gatedNext       = partitionGated_o;
        donePendingNext = donePending;
        doneNext        = 1'b0;

        unique case (state)
            PG_ACTIVE: begin
                if (reconfigReq_i) begin
                    if (reqMask == ~partitionGated_o) begin
                        // Nothing to change: acknowledge immediately.
                        doneNext = 1'b1;
                    end else begin
                        targetMaskNext  = reqMask;
                        donePendingNext = 1'b1;
                        stateNext       = PG_DRAIN;
                    end
                end
            end

            PG_DRAIN: begin
                gatedNext = ~targetMask;
                // Only powering a partition back up needs the settle delay.
                if (|(partitionGated_o & targetMask)) begin
                    stateNext     = PG_SETTLE;
                    settleCntNext = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    stateNext = PG_WAIT_READY;
                end
            end

            PG_SETTLE: begin
                if (settleCnt == '0) begin
                    stateNext = PG_WAIT_READY;
                end else begin
                    settleCntNext = settleCnt - CNT_W'(1);
                end
            end

            PG_WAIT_READY: begin
                if (ramReady_i) begin
                    stateNext       = PG_ACTIVE;
                    // The wait that follows reset is not a reconfiguration,
                    // so it completes without a done pulse.
                    doneNext        = donePending;
                    donePendingNext = 1'b0;
                end
            end

            default: begin
                stateNext = PG_WAIT_READY;
            end
        endcase
    end

endmodule
